// File: rtl/bp_reg_burst_pkg.sv
// Shared types and constants for the bytepipe burst register file.
package bpRegBurst_pkg;

    typedef enum logic [2:0] {
        S_CMD,
        S_LEN,
        S_WRDATA,
        S_WRACK,
        S_RDDATA
    } state_t;

    localparam int CMD_WR = 7;
    localparam int ADDR_W = 7;

    localparam logic [7:0] ACK_OK   = 8'hAC;
    localparam logic [7:0] ACK_NULL = 8'hEE;

    localparam int LEN_ZERO_MEANS = 256;

endpackage

// File: rtl/bp_reg_burst_serdes.sv
// Little-endian word assembler / serialiser with a byte-in-word counter.
module bp_word_serdes #(
    parameter int REG_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic               shiftIn,
    input  logic               shiftOut,
    input  logic [8*REG_W-1:0] loadWord,
    input  logic [7:0]         inByte,
    output logic [8*REG_W-1:0] nextWord,
    output logic [7:0]         outByte,
    output logic               lastByte
);

    localparam int W     = 8 * REG_W;
    localparam int CNT_W = $clog2(REG_W) + 1;

    logic [W-1:0]     bufQ;
    logic [CNT_W-1:0] cntQ;

    // Incoming bytes enter at the top so byte 0 ends up in bits 7:0.
    generate
        if (REG_W == 1) begin : gSingle
            assign nextWord = inByte;
        end else begin : gMulti
            assign nextWord = {inByte, bufQ[W-1:8]};
        end
    endgenerate

    assign outByte  = bufQ[7:0];
    assign lastByte = (cntQ == CNT_W'(REG_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            bufQ <= '0;
            cntQ <= '0;
        end else begin
            if (load)
                bufQ <= loadWord;
            else if (shiftIn)
                bufQ <= nextWord;
            else if (shiftOut)
                bufQ <= bufQ >> 8;

            if (clr)
                cntQ <= '0;
            else if (shiftIn || shiftOut)
                cntQ <= lastByte ? '0 : cntQ + 1'b1;
        end
    end

endmodule

// File: rtl/bp_reg_burst.sv
// Bytepipe-attached register file with burst access, wrap and read-only slots.
module bp_reg_burst
    import bpRegBurst_pkg::*;
#(
    parameter int                        N_REG     = 16,
    parameter int                        REG_W     = 2,
    parameter logic [N_REG-1:0]          RO_MASK   = '0,
    parameter logic [N_REG*8*REG_W-1:0]  RESET_VAL = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cg,
    input  logic [7:0]                 i_bp_data,
    input  logic                       i_bp_valid,
    output logic                       o_bp_ready,
    output logic [7:0]                 o_bp_data,
    output logic                       o_bp_valid,
    input  logic                       i_bp_ready,
    output logic [N_REG*8*REG_W-1:0]   o_reg,
    output logic [N_REG-1:0]           o_wrStrobe,
    input  logic [N_REG*8*REG_W-1:0]   i_ro
);

    localparam int RW = 8 * REG_W;

    state_t state, stateNext;

    logic                   wrQ;
    logic                   nullQ;
    logic [ADDR_W-1:0]      addrQ;
    logic [ADDR_W-1:0]      addrInc;
    logic [ADDR_W-1:0]      snapAddr;
    logic [8:0]             regLeft;
    logic [N_REG*RW-1:0]    regQ;
    logic [N_REG-1:0]       strobeQ;
    logic [RW-1:0]          snapWord;

    logic readyRaw;
    logic inAcc;
    logic outReady;
    logic sdClr;
    logic sdLoad;
    logic sdShiftIn;
    logic sdShiftOut;
    logic commit;
    logic regStep;

    logic [RW-1:0] sdNext;
    logic [7:0]    sdOut;
    logic          lastByte;

    assign readyRaw = (state == S_CMD) || (state == S_LEN)
                   || (state == S_WRDATA);
    assign o_bp_ready = readyRaw && i_cg && !i_rst;
    assign inAcc      = i_bp_valid && o_bp_ready;
    assign outReady   = i_bp_ready && i_cg;

    assign o_reg      = regQ;
    assign o_wrStrobe = strobeQ & {N_REG{i_cg}};

    assign addrInc  = (addrQ == ADDR_W'(N_REG - 1)) ? '0 : addrQ + 1'b1;
    assign snapAddr = (state == S_LEN) ? addrQ : addrInc;

    // One-cycle sample of the whole register keeps multi-byte reads untorn.
    always_comb begin
        snapWord = '0;
        for (int r = 0; r < N_REG; r++) begin
            if (!nullQ && snapAddr == ADDR_W'(r))
                snapWord = RO_MASK[r] ? i_ro[r*RW +: RW]
                                      : regQ[r*RW +: RW];
        end
    end

    always_comb begin
        stateNext  = state;
        o_bp_valid = 1'b0;
        o_bp_data  = 8'h00;
        sdClr      = 1'b0;
        sdLoad     = 1'b0;
        sdShiftIn  = 1'b0;
        sdShiftOut = 1'b0;
        commit     = 1'b0;
        regStep    = 1'b0;
        unique case (state)
            S_CMD: begin
                if (inAcc)
                    stateNext = S_LEN;
            end
            S_LEN: begin
                if (inAcc) begin
                    sdClr = 1'b1;
                    if (wrQ) begin
                        stateNext = S_WRDATA;
                    end else begin
                        sdLoad    = 1'b1;
                        stateNext = S_RDDATA;
                    end
                end
            end
            S_WRDATA: begin
                if (inAcc) begin
                    sdShiftIn = 1'b1;
                    if (lastByte) begin
                        commit  = 1'b1;
                        regStep = 1'b1;
                        if (regLeft == 9'd1)
                            stateNext = S_WRACK;
                    end
                end
            end
            S_WRACK: begin
                o_bp_valid = 1'b1;
                o_bp_data  = nullQ ? ACK_NULL : ACK_OK;
                if (outReady)
                    stateNext = S_CMD;
            end
            S_RDDATA: begin
                o_bp_valid = 1'b1;
                o_bp_data  = sdOut;
                if (outReady) begin
                    sdShiftOut = 1'b1;
                    if (lastByte) begin
                        regStep = 1'b1;
                        if (regLeft == 9'd1)
                            stateNext = S_CMD;
                        else
                            sdLoad = 1'b1;
                    end
                end
            end
            default: stateNext = S_CMD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_CMD;
            wrQ     <= 1'b0;
            nullQ   <= 1'b0;
            addrQ   <= '0;
            regLeft <= '0;
            regQ    <= RESET_VAL;
            strobeQ <= '0;
        end else if (i_cg) begin
            state   <= stateNext;
            strobeQ <= '0;
            if (state == S_CMD && inAcc) begin
                wrQ   <= i_bp_data[CMD_WR];
                addrQ <= i_bp_data[ADDR_W-1:0];
                nullQ <= int'(i_bp_data[ADDR_W-1:0]) >= N_REG;
            end
            if (state == S_LEN && inAcc)
                regLeft <= (i_bp_data == 8'd0) ? 9'(LEN_ZERO_MEANS)
                                               : {1'b0, i_bp_data};
            if (commit) begin
                for (int r = 0; r < N_REG; r++) begin
                    if (!nullQ && addrQ == ADDR_W'(r) && !RO_MASK[r]) begin
                        regQ[r*RW +: RW] <= sdNext;
                        strobeQ[r]       <= 1'b1;
                    end
                end
            end
            if (regStep) begin
                addrQ   <= addrInc;
                regLeft <= regLeft - 9'd1;
            end
        end else begin
            strobeQ <= '0;
        end
    end

    bp_word_serdes #(
        .REG_W(REG_W)
    ) uSerdes (
        .clk     (i_clk),
        .rst     (i_rst),
        .clr     (sdClr),
        .load    (sdLoad),
        .shiftIn (sdShiftIn),
        .shiftOut(sdShiftOut),
        .loadWord(snapWord),
        .inByte  (i_bp_data),
        .nextWord(sdNext),
        .outByte (sdOut),
        .lastByte(lastByte)
    );

endmodule

// File: tb/tb_bp_reg_burst.sv
// Randomised bench for bp_reg_burst against a register-array reference model.
module tb_bp_reg_burst;

    localparam int NR = 4;
    localparam logic [63:0] RV = 64'h4D4C_3B3A_2928_1716;

    logic        clk;
    logic        rst;
    logic        cg;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady;
    logic [7:0]  outData;
    logic        outValid;
    logic        outReady;
    logic [63:0] regs;
    logic [3:0]  strobe;
    logic [63:0] roBus;

    logic [15:0] roVal;
    logic [15:0] modelReg [NR];
    logic [7:0]  wrBytes [$];
    int          strobeLog [$];
    int          checks = 0;
    int          errors = 0;

    assign roBus = {16'hDEAD, roVal, 16'hBEAD, 16'hFACE};

    bp_reg_burst #(
        .N_REG    (NR),
        .REG_W    (2),
        .RO_MASK  (4'b0100),
        .RESET_VAL(RV)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_cg      (cg),
        .i_bp_data (inData),
        .i_bp_valid(inValid),
        .o_bp_ready(inReady),
        .o_bp_data (outData),
        .o_bp_valid(outValid),
        .i_bp_ready(outReady),
        .o_reg     (regs),
        .o_wrStrobe(strobe),
        .i_ro      (roBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        for (int r = 0; r < NR; r++)
            if (strobe[r]) strobeLog.push_back(r);

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void modelReset();
        for (int r = 0; r < NR; r++)
            modelReg[r] = RV[r*16 +: 16];
    endfunction

    function automatic logic [7:0] expByte(int addr, int i);
        logic [15:0] v;
        int r;
        if (addr >= NR) return 8'h00;
        r = (addr + i / 2) % NR;
        v = (r == 2) ? roVal : modelReg[r];
        return (i % 2) ? v[15:8] : v[7:0];
    endfunction

    task automatic sendByte(input logic [7:0] b);
        int g = 0;
        @(negedge clk);
        inValid = 1'b1;
        inData  = b;
        while (!inReady && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!inReady) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%h", b);
            inValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 inValid = 1'b0;
    endtask

    task automatic recvByte(input int pct, output logic [7:0] b);
        int g = 0;
        logic [7:0] held;
        bit stalled = 0;
        b = 8'h00;
        @(negedge clk);
        while (!outValid && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!outValid) begin
            checks++;
            errors++;
            $display("FAIL recv_timeout valid=%b", outValid);
            return;
        end
        g = 0;
        forever begin
            if (stalled) begin
                checks++;
                if (outData !== held || outValid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_stable got=%h/%b want=%h/1",
                             outData, outValid, held);
                end
            end
            if ($urandom_range(0, 99) < pct || g > 200) begin
                b = outData;
                outReady = 1'b1;
                @(posedge clk);
                #1 outReady = 1'b0;
                return;
            end
            held     = outData;
            stalled  = 1;
            outReady = 1'b0;
            g++;
            @(negedge clk);
        end
    endtask

    task automatic checkRegs(input string tag);
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (regs[r*16 +: 16] !== modelReg[r]) begin
                errors++;
                $display("FAIL %s_reg%0d got=%h want=%h",
                         tag, r, regs[r*16 +: 16], modelReg[r]);
            end
        end
    endtask

    task automatic doWrite(input int addr, input int len);
        int L;
        int want [$];
        logic [7:0] b;
        bit ok;
        L = (len == 0) ? 256 : len;
        strobeLog.delete();
        sendByte(8'h80 | 8'(addr));
        sendByte(8'(len));
        for (int i = 0; i < 2 * L; i++)
            sendByte(wrBytes[i]);
        recvByte(100, b);
        checks++;
        if (b !== ((addr >= NR) ? 8'hEE : 8'hAC)) begin
            errors++;
            $display("FAIL write_ack a=%0d got=%h", addr, b);
        end
        if (addr < NR) begin
            for (int k = 0; k < L; k++) begin
                int r = (addr + k) % NR;
                if (r != 2) begin
                    modelReg[r] = {wrBytes[2*k+1], wrBytes[2*k]};
                    want.push_back(r);
                end
            end
        end
        ok = (strobeLog.size() == want.size());
        if (ok)
            foreach (want[i])
                if (strobeLog[i] != want[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL write_strobe a=%0d got=%0d pulses want=%0d",
                     addr, strobeLog.size(), want.size());
        end
        checkRegs("write");
    endtask

    task automatic doRead(input int addr, input int len, input int pct);
        int L;
        logic [7:0] b;
        L = (len == 0) ? 256 : len;
        sendByte(8'(addr));
        sendByte(8'(len));
        checks++;
        if (outValid !== 1'b1 || inReady !== 1'b0) begin
            errors++;
            $display("FAIL read_start valid=%b ready=%b want=1/0",
                     outValid, inReady);
        end
        for (int i = 0; i < 2 * L; i++) begin
            recvByte(pct, b);
            checks++;
            if (b !== expByte(addr, i)) begin
                errors++;
                $display("FAIL read_byte a=%0d i=%0d got=%h want=%h",
                         addr, i, b, expByte(addr, i));
            end
        end
        @(negedge clk);
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL read_end valid=%b want=0", outValid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (inReady !== 1'b0 || outValid !== 1'b0 || outData !== 8'h00
            || strobe !== 4'h0 || regs !== RV) begin
            errors++;
            $display("FAIL reset_state rdy=%b v=%b d=%h s=%h reg=%h",
                     inReady, outValid, outData, strobe, regs);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ready=%b want=1", inReady);
        end
    endtask

    task automatic test_write_burst();
        wrBytes = '{8'h34, 8'h12, 8'h78, 8'h56};
        doWrite(1, 2);
        wrBytes = '{8'hC1, 8'hC3, 8'hD5, 8'hD7};
        doWrite(3, 2);
    endtask

    task automatic test_read_wrap();
        doRead(3, 3, 100);
    endtask

    task automatic test_ro();
        logic [7:0] b;
        wrBytes = '{8'h11, 8'h22};
        doWrite(2, 1);
        sendByte(8'h02);
        sendByte(8'h01);
        recvByte(100, b);
        checks++;
        if (b !== 8'hEF) begin
            errors++;
            $display("FAIL ro_lo got=%h want=ef", b);
        end
        roVal = 16'h1357;
        recvByte(100, b);
        checks++;
        if (b !== 8'hBE) begin
            errors++;
            $display("FAIL ro_atomic got=%h want=be", b);
        end
        doRead(2, 1, 100);
    endtask

    task automatic test_null();
        wrBytes = '{8'hAA, 8'hBB};
        doWrite(5, 1);
        doRead(5, 2, 100);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            int a = $urandom_range(0, 5);
            int l = $urandom_range(1, 6);
            if ($urandom_range(0, 1)) begin
                wrBytes.delete();
                for (int i = 0; i < 2 * l; i++)
                    wrBytes.push_back(8'($urandom));
                doWrite(a, l);
            end else begin
                doRead(a, l, 70);
            end
        end
    endtask

    task automatic test_back_to_back();
        doRead(0, 0, 30);
    endtask

    task automatic test_cg();
        logic [7:0] held;
        logic [7:0] b;
        sendByte(8'h01);
        sendByte(8'h01);
        @(negedge clk);
        cg       = 1'b0;
        outReady = 1'b1;
        held     = outData;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outValid !== 1'b1 || outData !== held || inReady !== 1'b0
                || strobe !== 4'h0) begin
                errors++;
                $display("FAIL cg_hold v=%b d=%h want=1/%h rdy=%b",
                         outValid, outData, held, inReady);
            end
        end
        outReady = 1'b0;
        cg       = 1'b1;
        for (int i = 0; i < 2; i++) begin
            recvByte(100, b);
            checks++;
            if (b !== expByte(1, i)) begin
                errors++;
                $display("FAIL cg_resume i=%0d got=%h want=%h",
                         i, b, expByte(1, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        strobeLog.delete();
        sendByte(8'h80);
        sendByte(8'h01);
        sendByte(8'h55);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (inReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready got=%b want=0", inReady);
        end
        rst = 1'b0;
        modelReset();
        #1;
        checks++;
        if (inReady !== 1'b1 || strobeLog.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_release rdy=%b strobes=%0d",
                     inReady, strobeLog.size());
        end
        checkRegs("reset_mid");
        doRead(0, 1, 100);
    endtask

    initial begin
        rst      = 1'b1;
        cg       = 1'b1;
        inData   = 8'h00;
        inValid  = 1'b0;
        outReady = 1'b0;
        roVal    = 16'hBEEF;
        modelReset();
        test_reset();
        test_write_burst();
        test_read_wrap();
        test_ro();
        test_null();
        test_random();
        test_back_to_back();
        test_cg();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_reg_burst.md
Name: bp_reg_burst

Overview:
- Bytepipe-attached register file; next generation of the 8b single-register bytepipe register memory.
- Generalised in three ways:
  - register width is REG_W bytes;
  - each command performs a burst of L consecutive registers with address auto-increment and wrap;
  - registers can be individually marked read-only and sourced from hardware.
- Sits behind usbfsSerial (or any bytepipe source) so a host can configure and observe on-chip registers in bursts.

Parameters:
- N_REG, 16, number of registers, in {2..128}.
- REG_W, 2, register width in bytes, in {1,2,4}.
- RO_MASK, {N_REG{1'b0}}, bit r set: register r is read-only; reads return i_ro slice r, writes are dropped.
- RESET_VAL, '0, N_REG*8*REG_W reset value of writable registers.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_cg  in  1  clock-gate enable; 0 freezes all state.
- i_bp_data  in  8  host-to-device byte.
- i_bp_valid  in  1  byte valid.
- o_bp_ready  out  1  byte accepted when valid && ready.
- o_bp_data  out  8  device-to-host byte.
- o_bp_valid  out  1  byte valid.
- i_bp_ready  in  1  downstream ready.
- o_reg  out  N_REG*8*REG_W  flattened writable register contents; register r at [r*8*REG_W +: 8*REG_W].
- o_wrStrobe  out  N_REG  one-cycle pulse on register r update.
- i_ro  in  N_REG*8*REG_W  read-only register sources; slices for non-RO registers are ignored.

Behaviour:
- Reset values: state=CMD, o_bp_ready=0 during reset, o_bp_valid=0, o_bp_data=0, o_wrStrobe=0, o_reg=RESET_VAL.
- Command byte: bit7=write(1)/read(0); bits6:0=start address A.
- Length byte: L = number of registers; L=0 means 256.
- Null burst: A >= N_REG. Writes are dropped, reads return 0x00, byte counts are unchanged.
- Address increment: addr==N_REG-1 ? 0 : addr+1. Wrap within a burst is legal.
- Byte order is little-endian: byte 0 is bits 7:0.
- FSM states: CMD, LEN, WRDATA, WRACK, RDDATA.
  - CMD: o_bp_ready=1. On accept, latch write/address → LEN.
  - LEN: o_bp_ready=1. On accept, latch L, clear byte/register counters.
    - Write → WRDATA.
    - Read: snapshot register A (or 0 if null) into a REG_W-byte shift buffer → RDDATA. o_bp_valid rises the cycle after the length byte is accepted.
  - WRDATA: o_bp_ready=1. Accept bytes into the assembly buffer.
    - On byte REG_W-1 accepted: next cycle the target register updates (unless null or RO), o_wrStrobe[r] pulses for one cycle, address increments.
    - After L*REG_W bytes → WRACK.
  - WRACK: o_bp_ready=0. o_bp_valid=1 with o_bp_data = 0xAC (normal burst) or 0xEE (null burst).
    - Hold until i_bp_ready → CMD.
    - A write to an RO register still returns 0xAC.
  - RDDATA: o_bp_ready=0, o_bp_valid=1, o_bp_data = current buffer byte. Data must be stable while valid && !ready.
    - On accept, shift the buffer.
    - After the last byte of a register, reload the next register snapshot combinationally for the following cycle, so there are no bubbles.
    - After L*REG_W bytes, o_bp_valid=0 → CMD.
- Snapshot atomicity: all REG_W bytes of one register come from a single-cycle sample. i_ro changes mid-register do not tear the value.
- Read-after-write: a read of a register written by the previous command returns the new value.
- i_cg=0: no state/register updates; o_bp_ready forced 0; o_bp_valid/o_bp_data hold; o_wrStrobe=0.
- Reset mid-burst: abandon the burst and return to reset values in the next cycle. Partially assembled write data is discarded; no register is updated.
- Counters: register count is 9b (up to 256); byte-in-register count is clog2(REG_W)+1 bits.

Decomposition:
- Package bpRegBurst_pkg:
  - FSM state enum;
  - CMD_WR bit index (7), ADDR_W=7;
  - ACK_OK=8'hAC, ACK_NULL=8'hEE;
  - LEN_ZERO_MEANS=256.
- One natural sub-module: bp_word_serdes (REG_W-byte LE assembler/serialiser with load/shift/done). The FSM and register array stay in the top.

Test Plan:
- N_REG=4, REG_W=2. Write burst cmd 0x81, len 0x02, data 34 12 78 56 → reg1=0x1234, reg2=0x5678; o_wrStrobe[1] then [2] pulse once each; ack 0xAC.
- Read cmd 0x03, len 0x03 after the above → bytes 00 00 (reg3), then wrap: reg0 reset value bytes, then 34 12.
- RO_MASK=4'b0100, i_ro reg2=0xBEEF. Write cmd 0x82 len 1 data 11 22 → reg2 stays 0xBEEF, no strobe, ack 0xAC. Read → EF BE.
- Null: cmd 0x85 len 1 data AA BB → ack 0xEE, no strobe. Read cmd 0x05 len 2 → four 0x00 bytes.
- Backpressure: i_bp_ready random 30% during read len 0x00 (256 regs) → exactly 512 bytes, o_bp_data stable while stalled, correct wrapped order.
- Reset asserted after first data byte of a write; then read → register unchanged, FSM accepts a new command byte cycle 1 after reset deassert.
